multdiv_seq: RTL
================

# multdiv_seq

Sequential signed 32-bit multiply/divide unit that sits beside the single-cycle ALU in the processor execute stage. It handles the multicycle operations the ALU does not implement. A one-cycle start pulse launches an operation; the unit returns a 32-bit result, an exception flag, and a one-cycle ready pulse, so the pipeline can stall on it.

## Interface
Parameters:
- none (datapath fixed at 32 bits, iteration count fixed at 32)

Ports:
- clock  in  1  sole clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- data_operandA  in  32  multiplicand / dividend, two's complement
- data_operandB  in  32  multiplier / divisor, two's complement
- ctrl_MULT  in  1  start-multiply pulse, sampled on rising edge
- ctrl_DIV  in  1  start-divide pulse, sampled on rising edge
- data_result  out  32  low 32 bits of product, or quotient
- data_exception  out  1  overflow or divide-by-zero for the completed op
- data_resultRDY  out  1  one-cycle pulse: result/exception valid

## Operation
- State machine: IDLE, MUL, DIV, DONE.
- Start:
  - Any edge with ctrl_MULT=1 latches A, B, clears the counter, and enters MUL.
  - Otherwise, ctrl_DIV=1 latches the operands and enters DIV.
  - If both are high, MULT wins.
- Restart: a start pulse in MUL, DIV or DONE aborts the current op and restarts with the new operands. The aborted op never raises RDY.
- MUL: radix-2 Booth on a 65-bit {product_hi, product_lo, q-1} register, one iteration per cycle, 32 iterations.
  - Result is product[31:0].
  - Exception = product[63:31] not all-equal, i.e. the result does not fit in signed 32 bits.
- DIV: restoring division on magnitudes |A|, |B|, one quotient bit per cycle, 32 iterations.
  - Quotient is negated if sign(A) ≠ sign(B); truncation is toward zero.
  - Remainder is discarded.
- DIV exceptions:
  - B=0: result 0x00000000, exception 1; iterations still run and are ignored.
  - A=0x80000000, B=0xFFFFFFFF: result 0x80000000, exception 1.
  - Otherwise exception 0.
- All widths: internal adders are 33-bit for Booth/remainder so no carry is lost. The counter is 6 bits.
- DONE: the registered result/exception are presented and RDY=1. The next state is IDLE unless a new start is present.
- data_result and data_exception hold their last completed values until the next DONE. Start and abort do not change them.

## Timing
- Reset (async, immediate): state IDLE, counter 0, data_result 0x00000000, data_exception 0, data_resultRDY 0.
- Latency, same for MUL, DIV and divide-by-zero:
  - Start sampled at edge 0.
  - Iterations occur at edges 1..32.
  - Edge 33 registers the final result (DIV sign fix applied here) and enters DONE.
  - data_resultRDY is high for exactly the cycle between edges 33 and 34.
- RDY is never high for two consecutive cycles unless back-to-back ops complete. Back-to-back issue: a start at the DONE edge (edge 33) gives the next RDY at edge 66.
- Reset asserted mid-operation: outputs go to reset values at once. No RDY follows deassertion until a new start.
- Operand inputs are ignored except at the start edge. Changing them mid-op has no effect.
- ctrl pulses held high for multiple cycles restart the op each cycle. RDY arrives 33 edges after the last high sample.

## Test plan
- MULT A=7, B=0xFFFFFFFD (−3): RDY exactly at edge 33 for one cycle, result 0xFFFFFFEB, exception 0. Also 0x00010000×0x00010000: result 0x00000000, exception 1.
- DIV A=0xFFFFFFF9 (−7), B=2: result 0xFFFFFFFD (−3), exception 0. Also 100/7: result 14.
- DIV 5/0: RDY at edge 33, result 0x00000000, exception 1. Also 0x80000000/0xFFFFFFFF: result 0x80000000, exception 1.
- Abort: MULT 3×4 at edge 0, then DIV 100/7 at edge 10: no RDY at edge 33, single RDY at edge 43 with result 14. ctrl_MULT and ctrl_DIV high together, 6/3: result 18 (MULT wins).
- Reset mid-op: MULT started at edge 0, reset pulsed at edge 20: outputs 0 immediately, RDY stays 0 for 100 cycles afterward.
- Random regression: 1000 random signed pairs, mixed MULT/DIV, back-to-back issue at each DONE. Compare against a reference model (low-32 product, truncating quotient, exception rules above) and check one RDY per completed op.

Source files
------------

// File: rtl/multdiv_seq.sv
// ============================================================================
//  Module      : multdiv_seq
//  Description : Sequential signed 32-bit multiplier (radix-2 Booth) and
//                restoring divider with start/abort and a one-cycle ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [5:0]  C_ITERS   = 6'd32;
    localparam logic [31:0] C_INT_MIN = 32'h8000_0000;
    localparam logic [31:0] C_NEG_ONE = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_count;

    // Booth register: [64:33] product high, [32:1] product low, [0] q(-1)
    logic [31:0] r_mcand;
    logic [64:0] r_prod;

    logic [31:0] r_divisor;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic        r_neg;
    logic        r_div_zero;
    logic        r_div_ovf;

    logic        w_start_mul;
    logic        w_start_div;
    logic        w_last;

    logic [32:0] w_mcand_ext;
    logic [32:0] w_booth_addend;
    logic [32:0] w_booth_sum;
    logic [64:0] w_prod_nxt;
    logic [63:0] w_product;
    logic        w_mul_ovf;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [31:0] w_quo_final;

    // Multiply takes priority when both start strobes are present
    assign w_start_mul = ctrl_MULT;
    assign w_start_div = ctrl_DIV & ~ctrl_MULT;
    assign w_last      = (r_count == C_ITERS);

    // ------------------------------------------------------------------
    // Booth step: 33-bit add keeps the true sign for the arithmetic shift
    // ------------------------------------------------------------------
    assign w_mcand_ext = {r_mcand[31], r_mcand};

    always_comb begin
        w_booth_addend = 33'd0;
        case (r_prod[1:0])
            2'b01:   w_booth_addend = w_mcand_ext;
            2'b10:   w_booth_addend = 33'd0 - w_mcand_ext;
            default: w_booth_addend = 33'd0;
        endcase
    end

    assign w_booth_sum = {r_prod[64], r_prod[64:33]} + w_booth_addend;
    assign w_prod_nxt  = {w_booth_sum, r_prod[32:1]};
    assign w_product   = r_prod[64:1];
    assign w_mul_ovf   = ~((&w_product[63:31]) | ~(|w_product[63:31]));

    // ------------------------------------------------------------------
    // Restoring division step on magnitudes
    // ------------------------------------------------------------------
    assign w_abs_a     = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    assign w_abs_b     = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
    assign w_div_shift = {r_rem, r_quo[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_divisor};
    assign w_div_ge    = ~w_div_diff[32];

    always_comb begin
        w_quo_final = r_neg ? (32'd0 - r_quo) : r_quo;
        if (r_div_zero) begin
            w_quo_final = 32'd0;
        end else if (r_div_ovf) begin
            w_quo_final = C_INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start_mul) begin
            w_state_nxt = ST_MUL;
        end else if (w_start_div) begin
            w_state_nxt = ST_DIV;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_MUL:  w_state_nxt = w_last ? ST_DONE : ST_MUL;
                ST_DIV:  w_state_nxt = w_last ? ST_DONE : ST_DIV;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count        <= 6'd0;
            r_mcand        <= 32'd0;
            r_prod         <= 65'd0;
            r_divisor      <= 32'd0;
            r_rem          <= 32'd0;
            r_quo          <= 32'd0;
            r_neg          <= 1'b0;
            r_div_zero     <= 1'b0;
            r_div_ovf      <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else if (w_start_mul) begin
            r_count <= 6'd0;
            r_mcand <= data_operandA;
            r_prod  <= {32'd0, data_operandB, 1'b0};
        end else if (w_start_div) begin
            r_count    <= 6'd0;
            r_divisor  <= w_abs_b;
            r_quo      <= w_abs_a;
            r_rem      <= 32'd0;
            r_neg      <= data_operandA[31] ^ data_operandB[31];
            r_div_zero <= (data_operandB == 32'd0);
            r_div_ovf  <= (data_operandA == C_INT_MIN) && (data_operandB == C_NEG_ONE);
        end else begin
            case (r_state)
                ST_MUL: begin
                    if (w_last) begin
                        data_result    <= w_product[31:0];
                        data_exception <= w_mul_ovf;
                    end else begin
                        r_prod  <= w_prod_nxt;
                        r_count <= r_count + 6'd1;
                    end
                end
                ST_DIV: begin
                    if (w_last) begin
                        data_result    <= w_quo_final;
                        data_exception <= r_div_zero | r_div_ovf;
                    end else begin
                        r_rem   <= w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0];
                        r_quo   <= {r_quo[30:0], w_div_ge};
                        r_count <= r_count + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_resultRDY = (r_state == ST_DONE);

endmodule

`default_nettype wire
